// File: rtl/adc_dly_cal_ctrl.sv
// ADC capture-lane bring-up and IODELAY tap calibration.
// Sequences lane resets, sweeps taps, loads the centre of the widest eye.
module adc_dly_cal_ctrl #(
  parameter int CNTVALUE_WIDTH = 5,
  parameter int TAP_MAX        = 31,
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int SAMPLE_CYCLES  = 64,
  parameter int MIN_EYE        = 4
) (
  input  logic                      refclk,
  input  logic                      rst_sync,
  input  logic                      cal_start,
  input  logic                      dlyctrl_rdy,
  input  logic                      pattern_ok,
  output logic                      rst_bufr,
  output logic                      rst_iserdes,
  output logic                      dly_ld,
  output logic [CNTVALUE_WIDTH-1:0] dly_tap,
  output logic                      cal_busy,
  output logic                      cal_done,
  output logic                      cal_fail,
  output logic [CNTVALUE_WIDTH:0]   eye_width
);

  localparam int TW = CNTVALUE_WIDTH + 1;
  localparam int C1 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CMAX = (C1 > SAMPLE_CYCLES) ? C1 : SAMPLE_CYCLES;
  localparam int CNW = $clog2(CMAX + 1);

  typedef logic [TW-1:0]  tap_t;
  typedef logic [CNW-1:0] cnt_t;

  localparam tap_t TAP_LAST = tap_t'(TAP_MAX);
  localparam tap_t EYE_MIN  = tap_t'(MIN_EYE);
  localparam cnt_t RST_LAST = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t SET_LAST = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t SMP_LAST = cnt_t'(SAMPLE_CYCLES - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WRDY   = 4'd1;
  localparam logic [3:0] S_BUFR   = 4'd2;
  localparam logic [3:0] S_SERDES = 4'd3;
  localparam logic [3:0] S_LOAD   = 4'd4;
  localparam logic [3:0] S_SETTLE = 4'd5;
  localparam logic [3:0] S_SAMPLE = 4'd6;
  localparam logic [3:0] S_EVAL   = 4'd7;
  localparam logic [3:0] S_CENTER = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_FAIL   = 4'd10;

  logic [3:0] state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  tap_t       tap_q, tap_d;
  logic       pass_q, pass_d;
  tap_t       cur_start_q, cur_start_d;
  tap_t       cur_len_q, cur_len_d;
  tap_t       best_start_q, best_start_d;
  tap_t       best_len_q, best_len_d;
  logic       rst_bufr_q, rst_bufr_d;
  logic       rst_iserdes_q, rst_iserdes_d;
  logic       dly_ld_q, dly_ld_d;
  logic [CNTVALUE_WIDTH-1:0] dly_tap_q, dly_tap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  tap_t       eye_q, eye_d;

  tap_t new_len;
  tap_t center;
  logic in_lane;

  assign new_len = cur_len_q + tap_t'(1);
  assign center  = best_start_q + ((best_len_q - tap_t'(1)) >> 1);
  assign in_lane = (state_q >= S_BUFR) && (state_q <= S_CENTER);

  // Next-state and registered-output logic for the calibration sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tap_d         = tap_q;
    pass_d        = pass_q;
    cur_start_d   = cur_start_q;
    cur_len_d     = cur_len_q;
    best_start_d  = best_start_q;
    best_len_d    = best_len_q;
    rst_bufr_d    = rst_bufr_q;
    rst_iserdes_d = rst_iserdes_q;
    dly_ld_d      = 1'b0;
    dly_tap_d     = dly_tap_q;
    busy_d        = busy_q;
    done_d        = done_q;
    fail_d        = fail_q;
    eye_d         = eye_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (cal_start) begin
          state_d       = S_WRDY;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          fail_d        = 1'b0;
          tap_d         = '0;
          cur_start_d   = '0;
          cur_len_d     = '0;
          best_start_d  = '0;
          best_len_d    = '0;
          rst_bufr_d    = 1'b1;
          rst_iserdes_d = 1'b1;
        end
      end
      S_WRDY: begin
        rst_bufr_d    = 1'b1;
        rst_iserdes_d = 1'b1;
        if (dlyctrl_rdy) begin
          state_d = S_BUFR;
          cnt_d   = '0;
        end
      end
      S_BUFR: begin
        if (cnt_q == RST_LAST) begin
          state_d    = S_SERDES;
          cnt_d      = '0;
          rst_bufr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_SERDES: begin
        if (cnt_q == RST_LAST) begin
          state_d       = S_LOAD;
          cnt_d         = '0;
          rst_iserdes_d = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_LOAD: begin
        dly_ld_d  = 1'b1;
        dly_tap_d = CNTVALUE_WIDTH'(tap_q);
        state_d   = S_SETTLE;
        cnt_d     = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_SAMPLE: begin
        pass_d = pass_q & pattern_ok;
        if (cnt_q == SMP_LAST) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_EVAL: begin
        if (pass_q) begin
          cur_len_d = new_len;
          if (cur_len_q == '0) cur_start_d = tap_q;
          if (new_len > best_len_q) begin
            best_len_d   = new_len;
            best_start_d = (cur_len_q == '0) ? tap_q : cur_start_q;
          end
        end else begin
          cur_len_d = '0;
        end
        if (tap_q == TAP_LAST) begin
          state_d = S_CENTER;
        end else begin
          tap_d   = tap_q + tap_t'(1);
          state_d = S_LOAD;
        end
      end
      S_CENTER: begin
        dly_ld_d = 1'b1;
        eye_d    = best_len_q;
        busy_d   = 1'b0;
        if (best_len_q >= EYE_MIN) begin
          dly_tap_d = CNTVALUE_WIDTH'(center);
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          dly_tap_d = '0;
          fail_d    = 1'b1;
          state_d   = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Losing IDELAYCTRL lock invalidates every tap scored so far
    if (in_lane && !dlyctrl_rdy) begin
      state_d       = S_WRDY;
      cnt_d         = '0;
      tap_d         = '0;
      cur_start_d   = '0;
      cur_len_d     = '0;
      best_start_d  = '0;
      best_len_d    = '0;
      rst_bufr_d    = 1'b1;
      rst_iserdes_d = 1'b1;
      dly_ld_d      = 1'b0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      fail_d        = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge refclk) begin
    if (rst_sync) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tap_q         <= '0;
      pass_q        <= 1'b0;
      cur_start_q   <= '0;
      cur_len_q     <= '0;
      best_start_q  <= '0;
      best_len_q    <= '0;
      rst_bufr_q    <= 1'b1;
      rst_iserdes_q <= 1'b1;
      dly_ld_q      <= 1'b0;
      dly_tap_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      eye_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tap_q         <= tap_d;
      pass_q        <= pass_d;
      cur_start_q   <= cur_start_d;
      cur_len_q     <= cur_len_d;
      best_start_q  <= best_start_d;
      best_len_q    <= best_len_d;
      rst_bufr_q    <= rst_bufr_d;
      rst_iserdes_q <= rst_iserdes_d;
      dly_ld_q      <= dly_ld_d;
      dly_tap_q     <= dly_tap_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      eye_q         <= eye_d;
    end
  end

  assign rst_bufr    = rst_bufr_q;
  assign rst_iserdes = rst_iserdes_q;
  assign dly_ld      = dly_ld_q;
  assign dly_tap     = dly_tap_q;
  assign cal_busy    = busy_q;
  assign cal_done    = done_q;
  assign cal_fail    = fail_q;
  assign eye_width   = eye_q;

endmodule
